// File: rtl/imem_responder_pkg.sv
// Shared widths, NOP encoding and FSM state type for the instruction-memory responder.
// Optional misaligned-fetch trap is enabled by defining IMEM_MISALIGN_TRAP_EN.
package imem_responder_pkg;

  localparam int ADDR_SIZE  = 31;  // MSB index of a byte address
  localparam int INSTR_SIZE = 31;  // MSB index of an instruction word
  localparam int WIDX_W     = ADDR_SIZE - 1;

  localparam logic [INSTR_SIZE:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic [WIDX_W-1:0] word_idx(input logic [ADDR_SIZE:0] addr);
    return addr[ADDR_SIZE:2];
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side request/response bundle between the fetch stage (master) and the responder (slave).
// misalign_err exists only when IMEM_MISALIGN_TRAP_EN is defined.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [ADDR_SIZE:0]  req_addr;
  logic                resp_valid;
  logic                resp_ready;
  logic [INSTR_SIZE:0] resp_instr;
  logic [ADDR_SIZE:0]  resp_addr;
  logic                flush;
  logic                stall_out;
`ifdef IMEM_MISALIGN_TRAP_EN
  logic                misalign_err;

  modport master (output req_valid, req_addr, resp_ready, flush,
                  input  req_ready, resp_valid, resp_instr, resp_addr, stall_out, misalign_err);
  modport slave  (input  req_valid, req_addr, resp_ready, flush,
                  output req_ready, resp_valid, resp_instr, resp_addr, stall_out, misalign_err);
`else
  modport master (output req_valid, req_addr, resp_ready, flush,
                  input  req_ready, resp_valid, resp_instr, resp_addr, stall_out);
  modport slave  (input  req_valid, req_addr, resp_ready, flush,
                  output req_ready, resp_valid, resp_instr, resp_addr, stall_out);
`endif

endinterface

// File: rtl/imem_responder_array.sv
// Single-port word RAM: synchronous write, synchronous read with a held output register.
module imem_responder_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WIDTH       = 32
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // NOTE: no reset here -- a reset loop over the array would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch reads, back-pressure, flush and program load.
// Define IMEM_MISALIGN_TRAP_EN to answer misaligned fetches with NOP and misalign_err.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                  DEPTH_WORDS = 1024,
  parameter int                  LATENCY     = 2,
  parameter logic [INSTR_SIZE:0] NOP_INSTR   = NOP_ENC
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_responder_if.slave      bus,
  input  logic                 prog_we,
  input  logic [ADDR_SIZE:0]   prog_addr,
  input  logic [INSTR_SIZE:0]  prog_data
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_SIZE:0]  addr_q, addr_d;
  logic                req_ready;
  logic                accept;
  logic                rd_en;
  logic [IDX_W-1:0]    rd_idx;
  logic                wr_en;
  logic [INSTR_SIZE:0] ram_rdata;
  logic                resp_in_range;
  logic                resp_aligned;
  logic                unused_prog_bits;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    req_ready = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = addr_q[IDX_W+1:2];

    unique case (state_q)
      ST_IDLE: req_ready = !prog_we;
      // WAIT lasts LATENCY-1 cycles, so resp_valid rises LATENCY cycles after the accept cycle.
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        req_ready = bus.resp_ready;
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush || reset) req_ready = 1'b0;
    accept = bus.req_valid && req_ready;

    if (accept) begin
      addr_d = bus.req_addr;
      if (LATENCY == 1) begin
        state_d = ST_RESP;
        rd_en   = 1'b1;
        rd_idx  = bus.req_addr[IDX_W+1:2];
      end else begin
        state_d = ST_WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
    end

    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Loads are only taken in IDLE, where no read can be in progress on the single port.
  assign wr_en = prog_we && (state_q == ST_IDLE) && !reset && (word_idx(prog_addr) < DEPTH_LIM);
  assign unused_prog_bits = ^prog_addr[1:0];

  imem_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WIDTH       (INSTR_SIZE + 1)
  ) u_array (
    .clk   (clk),
    .en    (wr_en || rd_en),
    .we    (wr_en),
    .addr  (wr_en ? prog_addr[IDX_W+1:2] : rd_idx),
    .wdata (prog_data),
    .rdata (ram_rdata)
  );

  assign resp_in_range = word_idx(addr_q) < DEPTH_LIM;
`ifdef IMEM_MISALIGN_TRAP_EN
  assign resp_aligned     = (addr_q[1:0] == 2'b00);
  assign bus.misalign_err = (state_q == ST_RESP) && !resp_aligned;
`else
  assign resp_aligned = 1'b1;
`endif

  assign bus.req_ready  = req_ready;
  assign bus.stall_out  = bus.req_valid && !req_ready;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_addr  = addr_q;
  assign bus.resp_instr = (state_q == ST_RESP && resp_in_range && resp_aligned) ? ram_rdata
                                                                                 : NOP_INSTR;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: reset, load/read latency, back-pressure, flush,
// range, program-load priority, misalign, back-to-back throughput and mid-flight reset.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  imem_responder_if bus ();

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  exp_t        sb_q[$];
  logic [31:0] mem_model [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t make_exp(input logic [31:0] a);
    exp_t e;
    e.addr  = a;
    e.err   = 1'b0;
    if (a[31:2] >= 30'(DEPTH)) e.instr = NOP;
    else                        e.instr = mem_model[a[11:2]];
`ifdef IMEM_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) begin
      e.instr = NOP;
      e.err   = 1'b1;
    end
`endif
    return e;
  endfunction

  // Scoreboard monitor: every consumed response must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got addr=%h instr=%h, required no response", bus.resp_addr, bus.resp_instr);
      end else if (bus.resp_ready) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (bus.resp_addr !== e.addr || bus.resp_instr !== e.instr) begin
          errors++;
          $display("FAIL resp_data: got addr=%h instr=%h, required addr=%h instr=%h", bus.resp_addr, bus.resp_instr, e.addr, e.instr);
        end
`ifdef IMEM_MISALIGN_TRAP_EN
        checks++;
        if (bus.misalign_err !== e.err) begin
          errors++;
          $display("FAIL misalign_err: got %b, required %b (addr=%h)", bus.misalign_err, e.err, e.addr);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
    mem_model[a[11:2]] = d;
  endtask

  // Presents a request until accepted (bounded); pushes the expectation at the accept edge.
  task automatic do_req(input logic [31:0] a, input logic push);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      if (++n > 50) begin
        checks++;
        errors++;
        $display("FAIL req_accept_timeout: addr=%h never accepted, required accept within 50 cycles", a);
        break;
      end
    end
    if (push && bus.req_ready) sb_q.push_back(make_exp(a));
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.resp_ready = 1'b1;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", sb_q.size());
      sb_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b, required 0", bus.resp_valid); end
      if (bus.resp_instr !== NOP) begin errors++; $display("FAIL reset_resp_instr: got %h, required %h", bus.resp_instr, NOP); end
      if (bus.req_ready !== 1'b0 || bus.stall_out !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_accept: got req_ready=%b stall_out=%b, required 0/1", bus.req_ready, bus.stall_out);
      end
    end
    tick();
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_read();
    prog_write(32'h0, 32'hDEADBEEF);
    for (int i = 1; i < 16; i++) prog_write(32'(i * 4), 32'h1000_0000 + 32'(i * 32'h0101_0101));
    bus.resp_ready = 1'b1;
    do_req(32'h0, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got resp_valid=%b at +%0d, required 0", bus.resp_valid, i); end
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'hDEADBEEF || bus.resp_addr !== 32'h0) begin
      errors++;
      $display("FAIL latency_resp: got valid=%b instr=%h addr=%h, required 1/deadbeef/0", bus.resp_valid, bus.resp_instr, bus.resp_addr);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_instr, held_addr;
    int n = 0;
    bus.resp_ready = 1'b0;
    do_req(32'h8, 1'b1);
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    held_instr = bus.resp_instr;
    held_addr  = bus.resp_addr;
    tick();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_instr !== held_instr || bus.resp_addr !== held_addr || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b instr=%h addr=%h req_ready=%b, required 1/%h/%h/0",
                 bus.resp_valid, bus.resp_instr, bus.resp_addr, bus.req_ready, held_instr, held_addr);
      end
    end
    tick();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_same_cycle_accept: got req_ready=%b, required 1", bus.req_ready); end
    else sb_q.push_back(make_exp(32'h4));
    tick();
    bus.req_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    bus.resp_ready = 1'b1;
    do_req(32'h8, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hC;
    bus.flush     = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.stall_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_no_accept: got req_ready=%b stall_out=%b, required 0/1", bus.req_ready, bus.stall_out);
    end
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got resp_valid=%b req_ready=%b, required 0/1", bus.resp_valid, bus.req_ready);
    end
    if (bus.req_ready) sb_q.push_back(make_exp(32'hC));
    tick();
    bus.req_valid = 1'b0;
    drain();
  endtask

  task automatic test_range();
    bus.resp_ready = 1'b1;
    do_req(32'(DEPTH * 4), 1'b1);
    drain();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h14;
    prog_we       = 1'b1;
    prog_addr     = 32'h14;
    prog_data     = 32'hA5A5_5A5A;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.stall_out !== 1'b1) begin
      errors++;
      $display("FAIL prog_priority: got req_ready=%b stall_out=%b, required 0/1", bus.req_ready, bus.stall_out);
    end
    tick();
    prog_we = 1'b0;
    mem_model[5] = 32'hA5A5_5A5A;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL prog_then_accept: got req_ready=%b, required 1", bus.req_ready); end
    else sb_q.push_back(make_exp(32'h14));
    tick();
    bus.req_valid = 1'b0;
    drain();
  endtask

  task automatic test_misalign();
    bus.resp_ready = 1'b1;
    do_req(32'h2, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int last = 0;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      bus.req_addr = 32'h20 + 32'(i * 4);
      do begin
        @(negedge clk);
        n++;
      end while (!bus.req_ready && n < 20);
      if (i > 0) begin
        checks++;
        if (cyc - last != LAT) begin errors++; $display("FAIL b2b_interval: got %0d cycles, required %0d", cyc - last, LAT); end
      end
      last = cyc;
      if (bus.req_ready) sb_q.push_back(make_exp(bus.req_addr));
      tick();
    end
    bus.req_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    bus.resp_ready = 1'b1;
    do_req(32'hC, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_drop: got resp_valid=%b, required 0", bus.resp_valid); end
    end
    tick();
    do_req(32'h4, 1'b1);
    drain();
  endtask

  initial begin
    reset          = 1'b1;
    prog_we        = 1'b0;
    prog_addr      = '0;
    prog_data      = '0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    bus.flush      = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    #1;
    test_reset();
    test_load_read();
    test_backpressure();
    test_flush();
    test_range();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
